seq_mult_skip: RTL and testbench

- Parametrised sequential shift-add multiplier. Successor to the fixed 16-bit ring-counter multiplier.
- Adds a valid/ready handshake on both input and output, and a per-operation signed/unsigned mode.
- Low-power features: the accumulator is updated only on multiplier bits equal to 1, and the operation terminates early once the remaining multiplier bits are zero.
- Sits between an operand source and a result consumer in the datapath; one multiplication in flight at a time.

---
 rtl/seq_mult_skip_if.sv | 27 ++
 rtl/seq_mult_skip.sv | 137 +++++++++++++
 tb/tb_seq_mult_skip.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_skip_if.sv
// Operand/result handshake bundle for seq_mult_skip: operands flow from the
// source (master) into the multiplier (slave), products flow back.
interface seq_mult_skip_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [CW-1:0]      cycles;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, cycles
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, cycles
  );
endinterface

// File: rtl/seq_mult_skip.sv
// Sequential shift-add multiplier working on operand magnitudes, with a sign fix-up
// at the end, accumulator writes only on set multiplier bits and optional early exit.
module seq_mult_skip #(
  parameter int WIDTH      = 16,
  parameter int EARLY_TERM = 1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult_skip_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [PW-1:0]    mcand_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    product_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cycles_r;
  logic             neg_r;

  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             neg_s;
  logic [PW-1:0]    add_s;
  logic [PW-1:0]    acc_next_s;
  logic [PW-1:0]    prod_next_s;
  logic [WIDTH-1:0] mplier_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic             last_s;

  assign bus.in_ready  = (state_r == S_IDLE) && rst;
  assign bus.out_valid = (state_r == S_DONE);
  assign bus.product   = product_r;
  assign bus.cycles    = cycles_r;

  // Operand magnitudes, next-step datapath values and the RUN exit condition.
  always_comb begin
    abs_a_s       = bus.a;
    abs_b_s       = bus.b;
    neg_s         = 1'b0;
    add_s         = acc_r + mcand_r;
    acc_next_s    = acc_r;
    mplier_next_s = mplier_r >> 1;
    cnt_next_s    = cnt_r + CNT_ONE;

    if (bus.is_signed) begin
      neg_s = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      // The most negative value negates to itself, which is the correct unsigned magnitude.
      if (bus.a[WIDTH-1]) begin
        abs_a_s = -bus.a;
      end else begin
        abs_a_s = bus.a;
      end
      if (bus.b[WIDTH-1]) begin
        abs_b_s = -bus.b;
      end else begin
        abs_b_s = bus.b;
      end
    end else begin
      neg_s = 1'b0;
    end

    if (mplier_r[0]) begin
      acc_next_s = add_s;
    end else begin
      acc_next_s = acc_r;
    end

    if (neg_r) begin
      prod_next_s = -acc_next_s;
    end else begin
      prod_next_s = acc_next_s;
    end

    last_s = (cnt_next_s == CNT_LAST) ||
             ((EARLY_TERM != 0) && (mplier_next_s == {WIDTH{1'b0}}));
  end

  // Control FSM and datapath registers; the accumulator is written only on set multiplier bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      mcand_r   <= {PW{1'b0}};
      acc_r     <= {PW{1'b0}};
      product_r <= {PW{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      cycles_r  <= {CW{1'b0}};
      neg_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_r  <= {{WIDTH{1'b0}}, abs_a_s};
            mplier_r <= abs_b_s;
            neg_r    <= neg_s;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            state_r  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= add_s;
          end
          mcand_r  <= {mcand_r[PW-2:0], 1'b0};
          mplier_r <= mplier_next_s;
          cnt_r    <= cnt_next_s;
          if (last_s) begin
            product_r <= prod_next_s;
            cycles_r  <= cnt_next_s;
            state_r   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_skip.sv
// Randomized and directed bench for seq_mult_skip: one early-terminating and one
// full-length instance share stimulus and are checked against an arithmetic model.
module tb_seq_mult_skip;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seq_mult_skip_if #(.WIDTH(W)) if_et ();
  seq_mult_skip_if #(.WIDTH(W)) if_ft ();

  seq_mult_skip #(.WIDTH(W), .EARLY_TERM(1)) dut_et (.clk(clk), .rst(rst), .bus(if_et));
  seq_mult_skip #(.WIDTH(W), .EARLY_TERM(0)) dut_ft (.clk(clk), .rst(rst), .bus(if_ft));

  logic          sel_ft        = 1'b0;
  logic          drv_valid     = 1'b0;
  logic          drv_s         = 1'b0;
  logic          drv_out_ready = 1'b0;
  logic [W-1:0]  drv_a         = 16'h0000;
  logic [W-1:0]  drv_b         = 16'h0000;

  assign if_et.in_valid  = drv_valid & ~sel_ft;
  assign if_ft.in_valid  = drv_valid & sel_ft;
  assign if_et.out_ready = drv_out_ready & ~sel_ft;
  assign if_ft.out_ready = drv_out_ready & sel_ft;
  assign if_et.a         = drv_a;
  assign if_ft.a         = drv_a;
  assign if_et.b         = drv_b;
  assign if_ft.b         = drv_b;
  assign if_et.is_signed = drv_s;
  assign if_ft.is_signed = drv_s;

  wire          obs_in_ready  = sel_ft ? if_ft.in_ready  : if_et.in_ready;
  wire          obs_out_valid = sel_ft ? if_ft.out_valid : if_et.out_valid;
  wire [2*W-1:0] obs_product  = sel_ft ? if_ft.product   : if_et.product;
  wire [4:0]    obs_cycles    = sel_ft ? if_ft.cycles    : if_et.cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Accumulator register writes observed while the early-terminating instance runs.
  int            acc_writes = 0;
  logic          prev_run   = 1'b0;
  logic [2*W-1:0] prev_acc  = 32'h0;

  always @(negedge clk) begin
    if (prev_run && (dut_et.acc_r !== prev_acc)) acc_writes <= acc_writes + 1;
    prev_run <= !if_et.in_ready && !if_et.out_valid && rst;
    prev_acc <= dut_et.acc_r;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int exp_cycles(input logic [W-1:0] b, input bit s, input bit ft);
    int mag;
    int n;
    if (ft) return W;
    mag = (s && b[W-1]) ? (65536 - int'(b)) : int'(b);
    n = 1;
    for (int i = 0; i < W; i++) if (((mag >> i) & 1) != 0) n = i + 1;
    return n;
  endfunction

  task automatic do_op(input bit ft, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input int bp);
    logic [31:0] ep;
    int ec;
    int edges;
    int guard;
    ep = exp_prod(a, b, s);
    ec = exp_cycles(b, s, ft);
    @(negedge clk);
    sel_ft = ft; drv_a = a; drv_b = b; drv_s = s; drv_valid = 1'b1; drv_out_ready = 1'b0;
    guard = 0;
    while (!obs_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("in_ready_before_accept", obs_in_ready, 1);
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_a = W'($urandom); drv_b = W'($urandom); drv_s = 1'($urandom);
    edges = 0;
    while (!obs_out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("out_valid", obs_out_valid, 1);
    check_eq("latency", edges, ec);
    check_eq("product", obs_product, ep);
    check_eq("cycles", obs_cycles, ec);
    repeat (bp) begin
      @(negedge clk);
      drv_a = W'($urandom); drv_b = W'($urandom); drv_valid = 1'($urandom);
      check_eq("hold_product", obs_product, ep);
      check_eq("hold_cycles", obs_cycles, ec);
      check_eq("hold_in_ready", obs_in_ready, 0);
      check_eq("hold_out_valid", obs_out_valid, 1);
    end
    @(negedge clk);
    drv_valid = 1'b0; drv_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("out_valid_drop", obs_out_valid, 0);
    check_eq("in_ready_rise", obs_in_ready, 1);
    drv_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    logic [W-1:0] pb;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", if_et.in_ready, 0);
    check_eq("rst_out_valid", if_et.out_valid, 0);
    check_eq("rst_product", if_et.product, 0);
    check_eq("rst_cycles", if_ft.cycles, 0);
    rst = 1'b1;
    #1;
    check_eq("rel_in_ready_et", if_et.in_ready, 1);
    check_eq("rel_in_ready_ft", if_ft.in_ready, 1);

    do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    wr0 = acc_writes;
    do_op(1'b0, 16'h0003, 16'h0005, 1'b0, 0);
    pb = 16'h0005;
    check_eq("acc_writes", acc_writes - wr0, $countones(pb));
    do_op(1'b1, 16'h0003, 16'h0005, 1'b0, 0);
    do_op(1'b0, 16'hFFFD, 16'h0007, 1'b1, 0);
    do_op(1'b0, 16'h8000, 16'h8000, 1'b1, 1);
    do_op(1'b0, 16'h8000, 16'h0001, 1'b1, 0);
    do_op(1'b0, 16'h1234, 16'h0000, 1'b0, 0);
    do_op(1'b0, 16'h0000, 16'hFFFF, 1'b0, 0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 0);
    do_op(1'b0, 16'h1234, 16'h5678, 1'b0, 10);
    do_op(1'b0, 16'h0006, 16'h0007, 1'b0, 0);

    // Reset during the fifth RUN cycle of a long operation.
    @(negedge clk);
    sel_ft = 1'b0; drv_a = 16'hFFFF; drv_b = 16'hFFFF; drv_s = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    check_eq("run_in_ready", if_et.in_ready, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", if_et.out_valid, 0);
    check_eq("mid_rst_product", if_et.product, 0);
    check_eq("mid_rst_cycles", if_et.cycles, 0);
    check_eq("mid_rst_in_ready", if_et.in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("post_rst_in_ready", if_et.in_ready, 1);
    do_op(1'b0, 16'h00FF, 16'h0101, 1'b0, 2);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom);
        1:       rb = W'($urandom) >> $urandom_range(0, 15);
        2:       rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
        default: rb = W'($urandom) | 16'h8000;
      endcase
      do_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
